// File: rtl/scan_mux_pkg.sv
// Shared mode/state encodings for the scanning channel multiplexer.
// MODE 10 and 11 both select HOLD.
package scan_mux_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SCAN   = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    function automatic state_t decode_mode(input logic [1:0] mode);
        state_t st;
        case (mode)
            MODE_MANUAL: st = ST_MANUAL;
            MODE_SCAN:   st = ST_SCAN;
            MODE_HOLD:   st = ST_HOLD;
            default:     st = ST_HOLD;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/dwell_cnt.sv
// Dwell counter 0..DWELL-1 with load-zero, enable and terminal-count flag.
// clr makes this cycle count as zero, so tc is valid on the entry edge itself.
module dwell_cnt #(
    parameter int DWELL = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] base;

    assign base = clr ? '0 : cnt_q;
    assign tc   = (base == LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else if (clr || en) begin
            cnt_q <= tc ? '0 : base + CW'(1);
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel data multiplexer with manual select, timed scan and hold.
// The state used at each edge is decoded from MODE, so a mode change wins over dwell expiry.
//
// state     | meaning
// ST_MANUAL | CH follows SEL; out-of-range SEL keeps CH and pulses ERR
// ST_SCAN   | CH advances (wrapping N-1 -> 0) every DWELL cycles
// ST_HOLD   | CH frozen, dwell frozen, OUT refreshed from current channel
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int DWELL = 4,
    localparam int SW   = $clog2(N)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [N*W-1:0]  IN,
    input  logic [SW-1:0]   SEL,
    input  logic [1:0]      MODE,
    output logic [W-1:0]    OUT,
    output logic [SW-1:0]   CH,
    output logic            STEP,
    output logic            ERR
);

    localparam logic [SW:0]   N_EXT   = (SW + 1)'(N);
    localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

    state_t         state_q;
    state_t         state_d;
    logic [SW-1:0]  ch_next;
    logic           err_d;
    logic           step_d;
    logic           scan_entry;
    logic           scan_en;
    logic           dwell_tc;
    logic [W-1:0]   slice_next;

    assign scan_en    = (state_d == ST_SCAN);
    assign scan_entry = scan_en && (state_q != ST_SCAN);

    dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (scan_entry),
        .en    (scan_en),
        .tc    (dwell_tc)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_MANUAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = decode_mode(MODE);
        ch_next = CH;
        err_d   = 1'b0;
        case (state_d)
            ST_MANUAL: begin
                if ({1'b0, SEL} < N_EXT) begin
                    ch_next = SEL;
                end else begin
                    err_d = 1'b1;
                end
            end
            ST_SCAN: begin
                if (dwell_tc) begin
                    ch_next = (CH == LAST_CH) ? '0 : CH + SW'(1);
                end
            end
            default: begin
                ch_next = CH;
            end
        endcase
        step_d = (ch_next != CH);
    end

    assign slice_next = IN[int'(ch_next) * W +: W];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT  <= '0;
            CH   <= '0;
            STEP <= 1'b0;
            ERR  <= 1'b0;
        end else begin
            OUT  <= slice_next;
            CH   <= ch_next;
            STEP <= step_d;
            ERR  <= err_d;
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// Directed scoreboard bench for scan_mux: main N=4/DWELL=3 build, an N=3 build
// for rejected selects and odd wrap, and a DWELL=1 build for per-cycle scanning.
module tb_scan_mux;

    typedef struct {
        string      tag;
        int         which;
        logic [7:0] out;
        logic [1:0] ch;
        logic       step;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in0, in2;
    logic [23:0] in1;
    logic [1:0]  sel0, sel1, sel2;
    logic [1:0]  mode0, mode1, mode2;
    logic [7:0]  out0, out1, out2;
    logic [1:0]  ch0, ch1, ch2;
    logic        step0, step1, step2;
    logic        err0, err1, err2;

    always #5 clk = ~clk;

    scan_mux #(.W(8), .N(4), .DWELL(3)) u0 (
        .CLK(clk), .RST_N(rst_n), .IN(in0), .SEL(sel0), .MODE(mode0),
        .OUT(out0), .CH(ch0), .STEP(step0), .ERR(err0)
    );

    scan_mux #(.W(8), .N(3), .DWELL(3)) u1 (
        .CLK(clk), .RST_N(rst_n), .IN(in1), .SEL(sel1), .MODE(mode1),
        .OUT(out1), .CH(ch1), .STEP(step1), .ERR(err1)
    );

    scan_mux #(.W(8), .N(4), .DWELL(1)) u2 (
        .CLK(clk), .RST_N(rst_n), .IN(in2), .SEL(sel2), .MODE(mode2),
        .OUT(out2), .CH(ch2), .STEP(step2), .ERR(err2)
    );

    task automatic push(input string tag, input int which, input logic [7:0] o,
                        input logic [1:0] c, input logic s, input logic e);
        exp_t x;
        x.tag = tag; x.which = which; x.out = o; x.ch = c; x.step = s; x.err = e;
        sb.push_back(x);
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_one();
        exp_t x;
        logic [7:0] o;
        logic [1:0] c;
        logic s, e;
        tests++;
        assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() != 0) begin
            x = sb.pop_front();
            case (x.which)
                1:       begin o = out1; c = ch1; s = step1; e = err1; end
                2:       begin o = out2; c = ch2; s = step2; e = err2; end
                default: begin o = out0; c = ch0; s = step0; e = err0; end
            endcase
            cmp({x.tag, ".out"},  o,          x.out);
            cmp({x.tag, ".ch"},   {6'd0, c},  {6'd0, x.ch});
            cmp({x.tag, ".step"}, {7'd0, s},  {7'd0, x.step});
            cmp({x.tag, ".err"},  {7'd0, e},  {7'd0, x.err});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_one();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in0 = {8'h44, 8'h33, 8'h22, 8'h11};
        in2 = {8'h44, 8'h33, 8'h22, 8'h11};
        in1 = {8'h33, 8'h22, 8'h11};
        sel0 = 2'd0; sel1 = 2'd0; sel2 = 2'd0;
        mode0 = 2'b00; mode1 = 2'b00; mode2 = 2'b00;

        #3;
        push("reset", 0, 8'h00, 2'd0, 1'b0, 1'b0); check_one();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // manual select and held select
        sel0 = 2'd2;
        push("man_sel2", 0, 8'h33, 2'd2, 1'b1, 1'b0); tick();
        push("man_held", 0, 8'h33, 2'd2, 1'b0, 1'b0); tick();
        sel0 = 2'd3;
        push("man_sel3", 0, 8'h44, 2'd3, 1'b1, 1'b0); tick();

        // scan from CH=3: wraps to 0 after three edges, then to 1
        mode0 = 2'b01;
        push("scan_e0", 0, 8'h44, 2'd3, 1'b0, 1'b0); tick();
        push("scan_e1", 0, 8'h44, 2'd3, 1'b0, 1'b0); tick();
        push("scan_wrap", 0, 8'h11, 2'd0, 1'b1, 1'b0); tick();
        push("scan_e3", 0, 8'h11, 2'd0, 1'b0, 1'b0); tick();
        push("scan_e4", 0, 8'h11, 2'd0, 1'b0, 1'b0); tick();
        push("scan_adv1", 0, 8'h22, 2'd1, 1'b1, 1'b0); tick();
        push("scan_e6", 0, 8'h22, 2'd1, 1'b0, 1'b0); tick();

        // hold mid-dwell, refresh OUT from changed input
        mode0 = 2'b10;
        push("hold_enter", 0, 8'h22, 2'd1, 1'b0, 1'b0); tick();
        in0[15:8] = 8'hA5;
        push("hold_refresh", 0, 8'hA5, 2'd1, 1'b0, 1'b0); tick();
        push("hold_stay", 0, 8'hA5, 2'd1, 1'b0, 1'b0); tick();
        mode0 = 2'b01;
        push("rescan_e0", 0, 8'hA5, 2'd1, 1'b0, 1'b0); tick();
        push("rescan_e1", 0, 8'hA5, 2'd1, 1'b0, 1'b0); tick();
        push("rescan_adv", 0, 8'h33, 2'd2, 1'b1, 1'b0); tick();
        in0[15:8] = 8'h22;

        // asynchronous reset mid-scan while CH=2
        #2 rst_n = 1'b0;
        #1;
        push("reset_async", 0, 8'h00, 2'd0, 1'b0, 1'b0); check_one();
        @(posedge clk); #1;
        rst_n = 1'b1;
        push("post_rst_e0", 0, 8'h11, 2'd0, 1'b0, 1'b0); tick();
        push("post_rst_e1", 0, 8'h11, 2'd0, 1'b0, 1'b0); tick();
        push("post_rst_adv", 0, 8'h22, 2'd1, 1'b1, 1'b0); tick();

        // mode change at dwell expiry takes priority
        push("prio_e0", 0, 8'h22, 2'd1, 1'b0, 1'b0); tick();
        push("prio_e1", 0, 8'h22, 2'd1, 1'b0, 1'b0); tick();
        mode0 = 2'b00; sel0 = 2'd3;
        push("prio_manual", 0, 8'h44, 2'd3, 1'b1, 1'b0); tick();
        mode0 = 2'b01;
        push("prio2_e0", 0, 8'h44, 2'd3, 1'b0, 1'b0); tick();
        push("prio2_e1", 0, 8'h44, 2'd3, 1'b0, 1'b0); tick();
        mode0 = 2'b11;
        push("prio_hold11", 0, 8'h44, 2'd3, 1'b0, 1'b0); tick();

        // DWELL=1 build advances every cycle
        mode2 = 2'b01;
        push("d1_adv1", 2, 8'h22, 2'd1, 1'b1, 1'b0); tick();
        push("d1_adv2", 2, 8'h33, 2'd2, 1'b1, 1'b0); tick();
        push("d1_adv3", 2, 8'h44, 2'd3, 1'b1, 1'b0); tick();
        push("d1_wrap", 2, 8'h11, 2'd0, 1'b1, 1'b0); tick();

        // N=3 build: rejected select and wrap from 2 to 0
        sel1 = 2'd2;
        push("n3_sel2", 1, 8'h33, 2'd2, 1'b1, 1'b0); tick();
        sel1 = 2'd3;
        push("n3_err", 1, 8'h33, 2'd2, 1'b0, 1'b1); tick();
        sel1 = 2'd2;
        push("n3_err_clr", 1, 8'h33, 2'd2, 1'b0, 1'b0); tick();
        mode1 = 2'b01; sel1 = 2'd3;
        push("n3_scan_e0", 1, 8'h33, 2'd2, 1'b0, 1'b0); tick();
        push("n3_scan_e1", 1, 8'h33, 2'd2, 1'b0, 1'b0); tick();
        push("n3_wrap", 1, 8'h11, 2'd0, 1'b1, 1'b0); tick();

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_left observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
